// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus bundle: control inputs, memory request/response channel and
// instruction output channel of the prefetch queue.
interface ifu_prefetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INS_WIDTH  = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  halt_in;
    logic                  redirect_valid_in;
    logic [ADDR_WIDTH-1:0] redirect_addr_in;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic                  mem_read_out;
    logic                  mem_valid_in;
    logic [INS_WIDTH-1:0]  mem_data_in;
    logic                  ins_valid_out;
    logic [INS_WIDTH-1:0]  ins_data_out;
    logic [ADDR_WIDTH-1:0] ins_pc_out;
    logic                  ins_ready_in;
    logic [CW-1:0]         count_out;
    logic                  idle_out;

    // The prefetch unit itself
    modport slave (
        input  halt_in, redirect_valid_in, redirect_addr_in,
        input  mem_valid_in, mem_data_in, ins_ready_in,
        output mem_addr_out, mem_read_out, ins_valid_out, ins_data_out,
        output ins_pc_out, count_out, idle_out
    );

    // The surrounding core / memory environment
    modport master (
        output halt_in, redirect_valid_in, redirect_addr_in,
        output mem_valid_in, mem_data_in, ins_ready_in,
        input  mem_addr_out, mem_read_out, ins_valid_out, ins_data_out,
        input  ins_pc_out, count_out, idle_out
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues one memory read at a time, queues the
// returned words with their fetch addresses, and hands them to the consumer
// in order. A redirect flushes the queue and discards any response that is
// still in flight for the old fetch stream.
module ifu_prefetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INS_WIDTH  = 32,
    parameter int                    DEPTH      = 4,
    parameter int                    PC_STEP    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input logic           clock_in,
    input logic           reset_in,
    ifu_prefetch_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_next;
    logic [PW-1:0]         r_head, w_head_next;
    logic [PW-1:0]         r_tail, w_tail_next;
    logic [CW-1:0]         r_count, w_count_arith, w_count_next;

    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [INS_WIDTH-1:0]  r_data_mem [DEPTH];

    logic                  r_mem_read;
    logic                  r_idle;
    logic                  r_ins_valid;
    logic [INS_WIDTH-1:0]  r_ins_data, w_ins_data_next;
    logic [ADDR_WIDTH-1:0] r_ins_pc, w_ins_pc_next;

    logic w_pop, w_push, w_room, w_redirect;

    assign w_redirect    = bus.redirect_valid_in;
    assign w_pop         = r_ins_valid & bus.ins_ready_in;
    assign w_push        = (r_state == ST_WAIT) & bus.mem_valid_in & ~w_redirect;
    assign w_count_arith = r_count + CW'(w_push) - CW'(w_pop);
    assign w_room        = (w_count_arith < CW'(DEPTH));

    // Next state, fetch address, queue pointers and the head-slot view
    always_comb begin
        // NOTE: every signal gets a default before any branch, otherwise an
        // unassigned path would infer a latch.
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_head_next     = r_head + PW'(w_pop);
        w_tail_next     = r_tail + PW'(w_push);
        w_count_next    = w_count_arith;

        if (w_redirect) begin
            w_fetch_pc_next = bus.redirect_addr_in;
            w_head_next     = '0;
            w_tail_next     = '0;
            w_count_next    = '0;
        end else if (w_push) begin
            w_fetch_pc_next = r_fetch_pc + ADDR_WIDTH'(PC_STEP);
        end

        case (r_state)
            ST_IDLE: begin
                if (!w_redirect && !bus.halt_in && w_room)
                    w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_redirect)
                    w_state_next = bus.mem_valid_in ? ST_IDLE : ST_DISCARD;
                else if (bus.mem_valid_in)
                    w_state_next = (!bus.halt_in && w_room) ? ST_WAIT : ST_IDLE;
            end
            ST_DISCARD: begin
                if (bus.mem_valid_in)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // The word being written this edge lands in the new head slot when
        // the queue was empty (or is being emptied) -- bypass storage then.
        if (w_push && (r_tail == w_head_next)) begin
            w_ins_data_next = bus.mem_data_in;
            w_ins_pc_next   = r_fetch_pc;
        end else begin
            w_ins_data_next = r_data_mem[w_head_next];
            w_ins_pc_next   = r_pc_mem[w_head_next];
        end
    end

    // State, pointers and registered outputs
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state     <= ST_IDLE;
            r_fetch_pc  <= RESET_ADDR;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_mem_read  <= 1'b0;
            r_idle      <= 1'b1;
            r_ins_valid <= 1'b0;
            r_ins_data  <= '0;
            r_ins_pc    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_fetch_pc  <= w_fetch_pc_next;
            r_head      <= w_head_next;
            r_tail      <= w_tail_next;
            r_count     <= w_count_next;
            r_mem_read  <= (w_state_next != ST_IDLE);
            r_idle      <= (w_state_next == ST_IDLE);
            r_ins_valid <= (w_count_next != '0);
            r_ins_data  <= w_ins_data_next;
            r_ins_pc    <= w_ins_pc_next;
        end
    end

    // Queue storage: responses written at the tail
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            // NOTE: the storage array is cleared on reset because the head
            // slot is always visible on the outputs and must read as zero.
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_data_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_pc_mem[r_tail]   <= r_fetch_pc;
            r_data_mem[r_tail] <= bus.mem_data_in;
        end
    end

    assign bus.mem_addr_out  = r_fetch_pc;
    assign bus.mem_read_out  = r_mem_read;
    assign bus.idle_out      = r_idle;
    assign bus.count_out     = r_count;
    assign bus.ins_valid_out = r_ins_valid;
    assign bus.ins_data_out  = r_ins_data;
    assign bus.ins_pc_out    = r_ins_pc;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed scenarios plus a random run,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_ifu_prefetch;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] data;
    } entry_t;

    logic clock_in = 1'b0;
    logic reset_in = 1'b1;

    ifu_prefetch_if #(.ADDR_WIDTH(AW), .INS_WIDTH(IW), .DEPTH(DEPTH)) bus ();

    ifu_prefetch #(
        .ADDR_WIDTH(AW), .INS_WIDTH(IW), .DEPTH(DEPTH), .PC_STEP(4), .RESET_ADDR('0)
    ) dut (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clock_in = ~clock_in;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: FIFO contents, next fetch address, whether a request
    // is outstanding and whether its response is to be thrown away.
    entry_t        mq[$];
    logic [AW-1:0] m_pc;
    bit            m_out;
    bit            m_drop;
    logic [AW-1:0] popped[$];
    logic [IW-1:0] data_xor = '0;

    task automatic model_reset();
        mq.delete();
        popped.delete();
        m_pc   = '0;
        m_out  = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic apply_reset();
        reset_in = 1'b1;
        bus.halt_in = 1'b0;
        bus.redirect_valid_in = 1'b0;
        bus.redirect_addr_in = '0;
        bus.mem_valid_in = 1'b0;
        bus.mem_data_in = '0;
        bus.ins_ready_in = 1'b0;
        repeat (2) @(negedge clock_in);
        reset_in = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, advance the model, then compare all outputs.
    task automatic step(input bit halt, input bit redir, input logic [AW-1:0] raddr,
                        input bit mv_want, input bit ready);
        bit mv;
        bit pop;
        mv = mv_want && bus.mem_read_out;
        bus.halt_in           = halt;
        bus.redirect_valid_in = redir;
        bus.redirect_addr_in  = raddr;
        bus.mem_valid_in      = mv;
        bus.mem_data_in       = bus.mem_addr_out ^ data_xor;
        bus.ins_ready_in      = ready;
        if (bus.ins_valid_out && ready) popped.push_back(bus.ins_pc_out);

        pop = (mq.size() != 0) && ready;
        if (redir) begin
            mq.delete();
            m_pc = raddr;
            if (m_out && mv) begin
                m_out = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_out && mv && m_drop) begin
                m_out = 1'b0;
                m_drop = 1'b0;
            end else if (m_out && mv) begin
                mq.push_back('{pc: m_pc, data: m_pc ^ data_xor});
                m_pc += 4;
                m_out = !halt && (mq.size() < DEPTH);
            end else if (!m_out) begin
                m_out = !halt && (mq.size() < DEPTH);
            end
        end

        @(posedge clock_in);
        @(negedge clock_in);
        bus.mem_valid_in = 1'b0;
        bus.redirect_valid_in = 1'b0;

        checks++;
        if (bus.mem_read_out !== m_out) begin
            failures++;
            $display("FAIL mem_read t=%0t got=%b exp=%b", $time, bus.mem_read_out, m_out);
        end
        checks++;
        if (bus.mem_addr_out !== m_pc) begin
            failures++;
            $display("FAIL mem_addr t=%0t got=%h exp=%h", $time, bus.mem_addr_out, m_pc);
        end
        checks++;
        if (bus.idle_out !== !m_out) begin
            failures++;
            $display("FAIL idle t=%0t got=%b exp=%b", $time, bus.idle_out, !m_out);
        end
        checks++;
        if (bus.count_out !== 3'(mq.size())) begin
            failures++;
            $display("FAIL count t=%0t got=%0d exp=%0d", $time, bus.count_out, mq.size());
        end
        checks++;
        if (bus.ins_valid_out !== (mq.size() != 0)) begin
            failures++;
            $display("FAIL ins_valid t=%0t got=%b exp=%b", $time, bus.ins_valid_out, mq.size() != 0);
        end
        if (mq.size() != 0) begin
            checks++;
            if (bus.ins_pc_out !== mq[0].pc || bus.ins_data_out !== mq[0].data) begin
                failures++;
                $display("FAIL head t=%0t got=%h/%h exp=%h/%h", $time,
                         bus.ins_pc_out, bus.ins_data_out, mq[0].pc, mq[0].data);
            end
        end
    endtask

    task automatic test_reset();
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            checks++;
            if (bus.mem_read_out !== 1'b0 || bus.mem_addr_out !== '0 || bus.idle_out !== 1'b1) begin
                failures++;
                $display("FAIL reset_req got rd=%b addr=%h idle=%b exp 0/0/1",
                         bus.mem_read_out, bus.mem_addr_out, bus.idle_out);
            end
            checks++;
            if (bus.ins_valid_out !== 1'b0 || bus.count_out !== '0) begin
                failures++;
                $display("FAIL reset_q got valid=%b count=%0d exp 0/0", bus.ins_valid_out, bus.count_out);
            end
            checks++;
            if (bus.ins_data_out !== '0 || bus.ins_pc_out !== '0) begin
                failures++;
                $display("FAIL reset_head got %h/%h exp 0/0", bus.ins_pc_out, bus.ins_data_out);
            end
            data_xor = 32'h5A5A_0F0F;
            for (int i = 0; i < 6; i++) step(0, 0, '0, 1, 0);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        data_xor = '0;
        for (int i = 0; i < 24; i++) step(0, 0, '0, 1, 1);
        checks++;
        if (popped.size() < 20) begin
            failures++;
            $display("FAIL stream_rate got=%0d pops exp>=20", popped.size());
        end
        for (int i = 0; i < popped.size(); i++) begin
            checks++;
            if (popped[i] !== 32'(i * 4)) begin
                failures++;
                $display("FAIL stream_pc[%0d] got=%h exp=%h", i, popped[i], 32'(i * 4));
            end
        end
    endtask

    task automatic test_fill();
        apply_reset();
        data_xor = 32'h1234_5678;
        for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0);
        checks++;
        if (bus.count_out !== 3'd4 || bus.mem_read_out !== 1'b0 || bus.ins_pc_out !== 32'h0) begin
            failures++;
            $display("FAIL fill_full got count=%0d rd=%b pc=%h exp 4/0/0",
                     bus.count_out, bus.mem_read_out, bus.ins_pc_out);
        end
        step(0, 0, '0, 0, 1);
        checks++;
        if (bus.mem_read_out !== 1'b1 || bus.mem_addr_out !== 32'h10 || bus.count_out !== 3'd3) begin
            failures++;
            $display("FAIL fill_reissue got rd=%b addr=%h count=%0d exp 1/10/3",
                     bus.mem_read_out, bus.mem_addr_out, bus.count_out);
        end
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= popped.size() || popped[i] !== 32'(i * 4)) begin
                failures++;
                $display("FAIL fill_pc[%0d] got=%h exp=%h", i,
                         (i < popped.size()) ? popped[i] : 32'hX, 32'(i * 4));
            end
        end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        data_xor = '0;
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        checks++;
        if (bus.mem_read_out !== 1'b1 || bus.mem_addr_out !== 32'h8) begin
            failures++;
            $display("FAIL redir_setup got rd=%b addr=%h exp 1/8", bus.mem_read_out, bus.mem_addr_out);
        end
        step(0, 1, 32'h100, 0, 1);
        step(0, 0, '0, 1, 1);
        checks++;
        if (bus.count_out !== '0 || bus.mem_read_out !== 1'b0 || bus.ins_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL redir_drop got count=%0d rd=%b valid=%b exp 0/0/0",
                     bus.count_out, bus.mem_read_out, bus.ins_valid_out);
        end
        step(0, 0, '0, 0, 1);
        checks++;
        if (bus.mem_read_out !== 1'b1 || bus.mem_addr_out !== 32'h100) begin
            failures++;
            $display("FAIL redir_next got rd=%b addr=%h exp 1/100", bus.mem_read_out, bus.mem_addr_out);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        step(0, 0, '0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, '0, 1, 0);
        checks++;
        if (bus.count_out !== 3'd2 || bus.mem_read_out !== 1'b1) begin
            failures++;
            $display("FAIL simul_setup got count=%0d rd=%b exp 2/1", bus.count_out, bus.mem_read_out);
        end
        step(0, 1, 32'h40, 1, 1);
        checks++;
        if (bus.count_out !== '0 || bus.idle_out !== 1'b1 || bus.mem_addr_out !== 32'h40) begin
            failures++;
            $display("FAIL simul_flush got count=%0d idle=%b addr=%h exp 0/1/40",
                     bus.count_out, bus.idle_out, bus.mem_addr_out);
        end
        step(0, 0, '0, 0, 1);
        checks++;
        if (bus.mem_read_out !== 1'b1 || bus.mem_addr_out !== 32'h40) begin
            failures++;
            $display("FAIL simul_next got rd=%b addr=%h exp 1/40", bus.mem_read_out, bus.mem_addr_out);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        step(0, 0, '0, 0, 0);
        step(1, 0, '0, 1, 0);
        checks++;
        if (bus.count_out !== 3'd1 || bus.idle_out !== 1'b1) begin
            failures++;
            $display("FAIL halt_push got count=%0d idle=%b exp 1/1", bus.count_out, bus.idle_out);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, '0, 1, 1);
            checks++;
            if (bus.mem_read_out !== 1'b0) begin
                failures++;
                $display("FAIL halt_block[%0d] got rd=%b exp 0", i, bus.mem_read_out);
            end
        end
        step(0, 0, '0, 0, 1);
        checks++;
        if (bus.mem_read_out !== 1'b1 || bus.mem_addr_out !== 32'h4) begin
            failures++;
            $display("FAIL halt_release got rd=%b addr=%h exp 1/4", bus.mem_read_out, bus.mem_addr_out);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        data_xor = 32'hCAFE_0000;
        step(0, 1, 32'hFFFF_FFFC, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1, 1);
        checks++;
        if (popped.size() < 2 || popped[0] !== 32'hFFFF_FFFC || popped[1] !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pcs got n=%0d first=%h second=%h exp FFFFFFFC/00000000", popped.size(),
                     (popped.size() > 0) ? popped[0] : 32'hX, (popped.size() > 1) ? popped[1] : 32'hX);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 1, 1);
        #2 reset_in = 1'b1;
        #1;
        checks++;
        if (bus.mem_read_out !== 1'b0 || bus.count_out !== '0 || bus.idle_out !== 1'b1 ||
            bus.mem_addr_out !== '0) begin
            failures++;
            $display("FAIL reset_mid got rd=%b count=%0d idle=%b addr=%h exp 0/0/1/0",
                     bus.mem_read_out, bus.count_out, bus.idle_out, bus.mem_addr_out);
        end
        @(negedge clock_in);
        reset_in = 1'b0;
        model_reset();
        step(0, 0, '0, 0, 1);
        checks++;
        if (bus.mem_read_out !== 1'b1 || bus.mem_addr_out !== '0) begin
            failures++;
            $display("FAIL reset_mid_next got rd=%b addr=%h exp 1/0", bus.mem_read_out, bus.mem_addr_out);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) data_xor = $urandom();
            step(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5),
                 $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 99) < 60),
                 ($urandom_range(0, 99) < 65));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_redirect_wait();
        test_simultaneous();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
